// File: rtl/cordic_pkg.sv
// Shared CORDIC constants for the QR array boundary (vectoring) and rotation cells.
package cordic_pkg;
    localparam int BITWIDTH_DEF   = 18;
    localparam int CORDIC_NUM_DEF = 14;
    localparam int PIPE_NUM       = 4;
    localparam int K_W            = 15;
    localparam logic signed [K_W-1:0] K = 15'sb010011011011101;
    // Last micro-rotation of each CORDIC stage.
    localparam int S0_LAST = 3;
    localparam int S1_LAST = 8;
    localparam int S2_LAST = 13;
endpackage

// File: rtl/cordic_vec_step.sv
// One combinational vectoring micro-rotation: rotate toward Y=0 using shift SHIFT.
module cordic_vec_step #(
    parameter int W     = 19,
    parameter int SHIFT = 0
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    output logic signed [W-1:0] x_nxt,
    output logic signed [W-1:0] y_nxt,
    output logic                d
);
    logic signed [W-1:0] xs;
    logic signed [W-1:0] ys;

    assign xs = x >>> SHIFT;
    assign ys = y >>> SHIFT;
    // Y == 0 counts as non-negative, matching the rotation cell's d convention.
    assign d     = y[W-1];
    assign x_nxt = d ? (x - ys) : (x + ys);
    assign y_nxt = d ? (y + xs) : (y - xs);
endmodule

// File: rtl/pe_v.sv
// Vectoring CORDIC boundary cell: drives Y to zero and emits scaled magnitude plus direction word.
module pe_v
    import cordic_pkg::*;
#(
    parameter int BITWIDTH   = BITWIDTH_DEF,
    parameter int CORDIC_NUM = CORDIC_NUM_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic                       valid_i,
    input  logic signed [BITWIDTH-1:0] X_i,
    input  logic signed [BITWIDTH-1:0] Y_i,
    output logic                       valid_o,
    output logic signed [BITWIDTH-1:0] X_o,
    output logic signed [BITWIDTH-1:0] Y_o,
    output logic [CORDIC_NUM-1:0]      angle_d_o
);
    localparam int IW = BITWIDTH + 1;
    localparam int PW = IW + K_W;

    function automatic logic signed [PW-1:0] mul_k(input logic signed [IW-1:0] v);
        return v * K;
    endfunction

    logic signed [IW-1:0] x_ext, y_ext;
    logic signed [IW-1:0] x_p0, y_p0, x_p1, y_p1, x_p2, y_p2;
    logic [S0_LAST:0]     d_p0;
    logic [S1_LAST:0]     d_p1;
    logic [S2_LAST:0]     d_p2;
    logic                 vld_p0, vld_p1, vld_p2;
    logic [CORDIC_NUM-1:0] d_comb;

    assign x_ext = {X_i[BITWIDTH-1], X_i};
    assign y_ext = {Y_i[BITWIDTH-1], Y_i};

    for (genvar k = 0; k < CORDIC_NUM; k++) begin : g_step
        logic signed [IW-1:0] xi, yi, xn, yn;
        logic                 dn;
        if (k == 0) begin : g_in
            assign xi = x_ext;
            assign yi = y_ext;
        end else if (k == S0_LAST + 1) begin : g_in
            assign xi = x_p0;
            assign yi = y_p0;
        end else if (k == S1_LAST + 1) begin : g_in
            assign xi = x_p1;
            assign yi = y_p1;
        end else begin : g_in
            assign xi = g_step[k-1].xn;
            assign yi = g_step[k-1].yn;
        end
        cordic_vec_step #(.W(IW), .SHIFT(k)) u_step (
            .x     (xi),
            .y     (yi),
            .x_nxt (xn),
            .y_nxt (yn),
            .d     (dn)
        );
        assign d_comb[k] = dn;
    end

    logic signed [PW-1:0]       px, py;
    logic signed [BITWIDTH-1:0] x_scl, y_scl;
    logic                       unused_prod;

    // Gain compensation: drop the redundant sign bit and the 14 fraction bits of K.
    assign px    = mul_k(x_p2);
    assign py    = mul_k(y_p2);
    assign x_scl = {px[BITWIDTH+14], px[BITWIDTH+12:BITWIDTH-4]};
    assign y_scl = {py[BITWIDTH+14], py[BITWIDTH+12:BITWIDTH-4]};
    assign unused_prod = ^{px[PW-1], px[BITWIDTH+13], px[BITWIDTH-5:0],
                           py[PW-1], py[BITWIDTH+13], py[BITWIDTH-5:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            valid_o   <= 1'b0;
            x_p0      <= '0;
            y_p0      <= '0;
            x_p1      <= '0;
            y_p1      <= '0;
            x_p2      <= '0;
            y_p2      <= '0;
            d_p0      <= '0;
            d_p1      <= '0;
            d_p2      <= '0;
            X_o       <= '0;
            Y_o       <= '0;
            angle_d_o <= '0;
        end else if (en_i) begin
            // S0: micro-rotations 0..3
            vld_p0    <= valid_i;
            x_p0      <= g_step[S0_LAST].xn;
            y_p0      <= g_step[S0_LAST].yn;
            d_p0      <= d_comb[S0_LAST:0];
            // S1: micro-rotations 4..8
            vld_p1    <= vld_p0;
            x_p1      <= g_step[S1_LAST].xn;
            y_p1      <= g_step[S1_LAST].yn;
            d_p1      <= {d_comb[S1_LAST:S0_LAST+1], d_p0};
            // S2: micro-rotations 9..13
            vld_p2    <= vld_p1;
            x_p2      <= g_step[S2_LAST].xn;
            y_p2      <= g_step[S2_LAST].yn;
            d_p2      <= {d_comb[S2_LAST:S1_LAST+1], d_p1};
            // S3: scaling
            valid_o   <= vld_p2;
            X_o       <= x_scl;
            Y_o       <= y_scl;
            angle_d_o <= d_p2;
        end
    end
endmodule
